// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: depth and count-width helpers
// and the reset values of the status flags.
package fifo_pkg;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Count must represent 0..DEPTH inclusive, hence one bit wider than a pointer.
  function automatic int count_width(input int addr_w);
    return addr_w + 1;
  endfunction

  localparam logic ERR_FLAG_RST = 1'b0;
  localparam logic RD_VALID_RST = 1'b0;

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer bundle of the parametrised FIFO; the FIFO takes the slave side.
interface fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  import fifo_pkg::*;

  localparam int CW = count_width(ADDR_W);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [CW-1:0]     afull_thresh;
  logic [CW-1:0]     aempty_thresh;
  logic              clr_err;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en, afull_thresh, aempty_thresh, clr_err,
    input  rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, afull_thresh, aempty_thresh, clr_err,
    output rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost
// thresholds, sticky overflow/underflow and optional first-word-fall-through.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FWFT   = 0
) (
  input logic         clk,
  input logic         rst_n,
  fifo_param_if.slave bus
);

  localparam int              DEPTH   = fifo_depth(ADDR_W);
  localparam int              CW      = count_width(ADDR_W);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;
  logic              overflow_q, underflow_q;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] ram_rdata;

  // Flags derive from the registered count only, never from pointer compare.
  assign bus.count        = count_q;
  assign bus.full         = (count_q == DEPTH_C);
  assign bus.empty        = (count_q == '0);
  assign bus.almost_full  = (count_q >= bus.afull_thresh);
  assign bus.almost_empty = (count_q <= bus.aempty_thresh);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  assign wr_acc = bus.wr_en & ~bus.full;
  assign rd_acc = bus.rd_en & ~bus.empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= ERR_FLAG_RST;
      underflow_q <= ERR_FLAG_RST;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // A new error in the same cycle as clr_err must not be lost.
      if (bus.wr_en & bus.full)      overflow_q <= 1'b1;
      else if (bus.clr_err)          overflow_q <= 1'b0;
      if (bus.rd_en & bus.empty)     underflow_q <= 1'b1;
      else if (bus.clr_err)          underflow_q <= 1'b0;
    end
  end

  fifo_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & rst_n),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign bus.rd_data  = ram_rdata;
    assign bus.rd_valid = ~bus.empty;
  end else begin : g_reg
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= RD_VALID_RST;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= ram_rdata;
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_param.sv
// Drives a registered-read and an FWFT instance with identical stimulus and
// checks both against a queue-based model every cycle plus directed literals.
module tb_fifo_param;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] wr_data;
  logic [4:0] afull_thresh, aempty_thresh;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [7:0] model_q[$];
  bit         m_ovf, m_unf, m_rvalid;
  logic [7:0] m_rdata;

  fifo_param_if #(.DATA_W(8), .ADDR_W(4)) bus_reg ();
  fifo_param_if #(.DATA_W(8), .ADDR_W(4)) bus_fwft ();

  assign bus_reg.wr_en          = wr_en;
  assign bus_reg.wr_data        = wr_data;
  assign bus_reg.rd_en          = rd_en;
  assign bus_reg.clr_err        = clr_err;
  assign bus_reg.afull_thresh   = afull_thresh;
  assign bus_reg.aempty_thresh  = aempty_thresh;
  assign bus_fwft.wr_en         = wr_en;
  assign bus_fwft.wr_data       = wr_data;
  assign bus_fwft.rd_en         = rd_en;
  assign bus_fwft.clr_err       = clr_err;
  assign bus_fwft.afull_thresh  = afull_thresh;
  assign bus_fwft.aempty_thresh = aempty_thresh;

  fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(0)) dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_reg)
  );

  fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1)) dut_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fwft)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs are held for exactly one rising edge; returns just after that edge.
  task automatic applyStimulus(input bit w, input logic [7:0] d, input bit r, input bit c);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue with accept/reject rules applied per edge.
  initial begin
    bit was_full, was_empty;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_q.delete();
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 8'h00;
      end else begin
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        m_rvalid  = rd_en && !was_empty;
        if (m_rvalid) m_rdata = model_q.pop_front();
        if (wr_en && !was_full) model_q.push_back(wr_data);
        if (wr_en && was_full) m_ovf = 1'b1;
        else if (clr_err)      m_ovf = 1'b0;
        if (rd_en && was_empty) m_unf = 1'b1;
        else if (clr_err)       m_unf = 1'b0;
      end
    end
  end

  // Per-cycle compare of both instances against the model, away from the edge.
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (check_en) begin
        n = model_q.size();
        checkOutput("reg.count",     bus_reg.count,        n);
        checkOutput("reg.full",      bus_reg.full,         n == DEPTH);
        checkOutput("reg.empty",     bus_reg.empty,        n == 0);
        checkOutput("reg.afull",     bus_reg.almost_full,  n >= afull_thresh);
        checkOutput("reg.aempty",    bus_reg.almost_empty, n <= aempty_thresh);
        checkOutput("reg.overflow",  bus_reg.overflow,     m_ovf);
        checkOutput("reg.underflow", bus_reg.underflow,    m_unf);
        checkOutput("reg.rd_valid",  bus_reg.rd_valid,     m_rvalid);
        checkOutput("reg.rd_data",   bus_reg.rd_data,      m_rdata);
        checkOutput("fwft.count",     bus_fwft.count,        n);
        checkOutput("fwft.full",      bus_fwft.full,         n == DEPTH);
        checkOutput("fwft.empty",     bus_fwft.empty,        n == 0);
        checkOutput("fwft.afull",     bus_fwft.almost_full,  n >= afull_thresh);
        checkOutput("fwft.aempty",    bus_fwft.almost_empty, n <= aempty_thresh);
        checkOutput("fwft.overflow",  bus_fwft.overflow,     m_ovf);
        checkOutput("fwft.underflow", bus_fwft.underflow,    m_unf);
        checkOutput("fwft.rd_valid",  bus_fwft.rd_valid,     n != 0);
        if (n != 0) checkOutput("fwft.rd_data", bus_fwft.rd_data, model_q[0]);
      end
    end
  end

  initial begin
    int wp, rp;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    afull_thresh = 5'd12; aempty_thresh = 5'd3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_en = 1'b1;

    checkOutput("rst.count",    bus_reg.count,    0);
    checkOutput("rst.empty",    bus_reg.empty,    1);
    checkOutput("rst.full",     bus_reg.full,     0);
    checkOutput("rst.rd_valid", bus_reg.rd_valid, 0);
    checkOutput("rst.rd_data",  bus_reg.rd_data,  0);
    checkOutput("rst.overflow", bus_reg.overflow, 0);

    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 1) begin
        checkOutput("fill.fwft_valid", bus_fwft.rd_valid, 1);
        checkOutput("fill.fwft_data",  bus_fwft.rd_data,  8'h01);
      end
    end
    checkOutput("fill.count", bus_reg.count, 16);
    checkOutput("fill.full",  bus_reg.full,  1);

    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkOutput("ovf.set",   bus_reg.overflow, 1);
    checkOutput("ovf.count", bus_reg.count,    16);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf.clear", bus_reg.overflow, 0);
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b1);
    checkOutput("ovf.set_wins", bus_reg.overflow, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 1; i <= 16; i++) begin
      checkOutput("drain.fwft_head", bus_fwft.rd_data, i);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain.rd_valid", bus_reg.rd_valid, 1);
      checkOutput("drain.rd_data",  bus_reg.rd_data,  i);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("drain.valid_drop", bus_reg.rd_valid, 0);
    checkOutput("drain.data_hold",  bus_reg.rd_data,  8'h10);
    checkOutput("drain.empty",      bus_reg.empty,    1);

    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("unf.set",      bus_reg.underflow, 1);
    checkOutput("unf.rd_valid", bus_reg.rd_valid,  0);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    checkOutput("unf.wr_count", bus_reg.count,     1);
    checkOutput("unf.sticky",   bus_reg.underflow, 1);
    checkOutput("unf.fwft_aa",  bus_fwft.rd_data,  8'hAA);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("unf.clear",    bus_reg.underflow, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("unf.read_aa",  bus_reg.rd_data,   8'hAA);
    checkOutput("unf.read_vld", bus_reg.rd_valid,  1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    checkOutput("thr.aempty0", bus_reg.almost_empty, 1);
    checkOutput("thr.afull0",  bus_reg.almost_full,  0);
    for (int c = 1; c <= 16; c++) begin
      applyStimulus(1'b1, 8'(c + 8'h40), 1'b0, 1'b0);
      checkOutput("thr.aempty", bus_reg.almost_empty, c <= 3);
      checkOutput("thr.afull",  bus_reg.almost_full,  c >= 12);
    end
    repeat (16) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    repeat (10) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (10) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("wrap.rd_data", bus_reg.rd_data, 8'h20 + i);
    end
    repeat (5) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("wrap.both_count", bus_reg.count, 5);
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("fwft.valid55", bus_fwft.rd_valid, 1);
    checkOutput("fwft.data55",  bus_fwft.rd_data,  8'h55);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fwft.pop_empty", bus_fwft.empty,    1);
    checkOutput("fwft.pop_valid", bus_fwft.rd_valid, 0);

    repeat (7) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    rst_n = 1'b1;
    checkOutput("mrst.count",      bus_fwft.count,    0);
    checkOutput("mrst.empty",      bus_fwft.empty,    1);
    checkOutput("mrst.fwft_valid", bus_fwft.rd_valid, 0);
    checkOutput("mrst.reg_valid",  bus_reg.rd_valid,  0);
    checkOutput("mrst.reg_count",  bus_reg.count,     0);

    wp = 50; rp = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 150 == 0) begin
        wp = $urandom_range(10, 90);
        rp = $urandom_range(10, 90);
      end
      if ($urandom_range(0, 39) == 0) afull_thresh  = 5'($urandom_range(0, 20));
      if ($urandom_range(0, 39) == 0) aempty_thresh = 5'($urandom_range(0, 20));
      rst_n = ($urandom_range(0, 399) != 0);
      applyStimulus($urandom_range(0, 99) < wp, 8'($urandom),
                    $urandom_range(0, 99) < rp, $urandom_range(0, 15) == 0);
      rst_n = 1'b1;
    end

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
